mem_stage: RTL and testbench

//  Pipeline MEM stage: L1 data cache in front of a multi-cycle backing data memory.

---
 rtl/mem_stage.sv | 164 ++++++++++++++++
 tb/tb_mem_stage.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Purpose : pipeline MEM stage; direct-mapped write-through L1 data cache
//           (no-write-allocate, write-update on store hit) in front of a
//           multi-cycle backing data memory.
// Latency : load hit 0 extra cycles; load miss and store each hold the
//           pipeline for MEM_LATENCY+1 cycles including the request cycle.
// Backpressure: stall_req=1 freezes the pipeline; the requester holds
//           is_load_in/is_store_in and the address/data until stall_req=0.
//
// Ports:
//   clk, reset     clock (rising edge), asynchronous active-high reset
//   alu_result_in  byte address for load/store, passthrough data otherwise
//   write_data_in  store data
//   rd_in          destination register  -> rd_out (combinational)
//   is_load_in     load request
//   is_store_in    store request (wins when both request flags are high)
//   is_write_in    register-write flag   -> is_write_out (combinational)
//   wb_data_out    load: cached word; otherwise alu_result_in
//   stall_req      1 = hold the pipeline
module mem_stage #(
  parameter int MEM_LATENCY = 10,
  parameter int NUM_LINES   = 4,
  parameter int LINE_WORDS  = 4,
  parameter int MEM_WORDS   = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] write_data_in,
  input  logic [4:0]  rd_in,
  input  logic        is_load_in,
  input  logic        is_store_in,
  input  logic        is_write_in,
  output logic [31:0] wb_data_out,
  output logic        stall_req,
  output logic [4:0]  rd_out,
  output logic        is_write_out
);

  localparam int OFF_W   = $clog2(LINE_WORDS);
  localparam int IDX_W   = $clog2(NUM_LINES);
  localparam int TAG_LSB = 2 + OFF_W + IDX_W;
  localparam int TAG_W   = 32 - TAG_LSB;
  localparam int MADDR_W = $clog2(MEM_WORDS);
  localparam int LBASE_W = MADDR_W - OFF_W;
  localparam int CNT_W   = $clog2(MEM_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, DONE} state_t;

  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q;

  // Address decomposition
  logic [OFF_W-1:0]   off;
  logic [IDX_W-1:0]   idx;
  logic [TAG_W-1:0]   tag;
  logic [MADDR_W-1:0] mem_addr;
  logic [LBASE_W-1:0] line_base;
  logic               unused_addr_bits;

  assign off              = alu_result_in[2 +: OFF_W];
  assign idx              = alu_result_in[2 + OFF_W +: IDX_W];
  assign tag              = alu_result_in[TAG_LSB +: TAG_W];
  assign mem_addr         = alu_result_in[2 +: MADDR_W];
  assign line_base        = alu_result_in[2 + OFF_W +: LBASE_W];
  // Word access only: the byte offset bits carry no meaning here.
  assign unused_addr_bits = ^alu_result_in[1:0];

  // Cache arrays: only the valid bits are reset; tag/data are qualified by valid.
  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [31:0]          data_q [NUM_LINES][LINE_WORDS];

  // Backing memory: power-on contents, never touched by reset.
  // Word 64 is byte address 0x100.
  logic [31:0] mem_q [MEM_WORDS] = '{64: 32'hCAFEBABE, default: 32'h0};

  // Request decode: store has priority when both flags are high.
  logic is_st, is_ld, hit, last, fill_en, mem_we;

  assign is_st   = is_store_in;
  assign is_ld   = is_load_in && !is_store_in;
  assign hit     = valid_q[idx] && (tag_q[idx] == tag);
  assign last    = (cnt_q == CNT_W'(MEM_LATENCY - 1));
  assign fill_en = (state_q == RD_WAIT) && last;
  assign mem_we  = (state_q == WR_WAIT) && last;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (is_st)              state_d = WR_WAIT;
        else if (is_ld && !hit) state_d = RD_WAIT;
      end
      RD_WAIT: if (last) state_d = IDLE;   // held load hits on return to IDLE
      WR_WAIT: if (last) state_d = DONE;
      // DONE retires the store; the still-asserted is_store_in is ignored.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall_req = 1'b0;
    case (state_q)
      IDLE:    stall_req = is_st || (is_ld && !hit);
      RD_WAIT: stall_req = 1'b1;
      WR_WAIT: stall_req = 1'b1;
      DONE:    stall_req = 1'b0;
      default: stall_req = 1'b0;
    endcase
  end

  assign wb_data_out  = is_ld ? data_q[idx][off] : alu_result_in;
  assign rd_out       = rd_in;
  assign is_write_out = is_write_in;

  // ------------------------------------------------ memory latency counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (state_q == RD_WAIT || state_q == WR_WAIT) begin
      cnt_q <= last ? '0 : cnt_q + 1'b1;
    end else begin
      cnt_q <= '0;
    end
  end

  // --------------------------------------------------------- cache arrays
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
    end else if (fill_en) begin
      valid_q[idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[idx] <= tag;
      for (int w = 0; w < LINE_WORDS; w++) begin
        data_q[idx][w] <= mem_q[{line_base, OFF_W'(w)}];
      end
    end
    // Write-update keeps the cached copy coherent with the write-through.
    if (mem_we && hit) begin
      data_q[idx][off] <= write_data_in;
    end
  end

  // ------------------------------------------------------- backing memory
  // A reset during WR_WAIT forces IDLE, so an aborted store never writes.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_addr] <= write_data_in;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  localparam int LAT       = 10;
  localparam int OP_STALLS = LAT + 1;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] alu_result_in, write_data_in;
  logic [4:0]  rd_in;
  logic        is_load_in, is_store_in, is_write_in;
  logic [31:0] wb_data_out;
  logic        stall_req;
  logic [4:0]  rd_out;
  logic        is_write_out;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  mem_stage #(.MEM_LATENCY(LAT)) dut (
    .clk          (clk),
    .reset        (reset),
    .alu_result_in(alu_result_in),
    .write_data_in(write_data_in),
    .rd_in        (rd_in),
    .is_load_in   (is_load_in),
    .is_store_in  (is_store_in),
    .is_write_in  (is_write_in),
    .wb_data_out  (wb_data_out),
    .stall_req    (stall_req),
    .rd_out       (rd_out),
    .is_write_out (is_write_out)
  );

  always #5 clk = ~clk;

  task automatic drive_idle();
    is_load_in    = 1'b0;
    is_store_in   = 1'b0;
    alu_result_in = 32'h0;
    write_data_in = 32'h0;
  endtask

  task automatic issue(input bit ld, input bit st, input logic [31:0] addr,
                       input logic [31:0] data);
    is_load_in    = ld;
    is_store_in   = st;
    alu_result_in = addr;
    write_data_in = data;
  endtask

  // Counts stalled cycles (sampled on the falling edge) until stall_req drops.
  task automatic wait_ready(output int stalls, output logic [31:0] wb, output bit to);
    bit done;
    done   = 1'b0;
    stalls = 0;
    to     = 1'b0;
    wb     = 'x;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      if (!stall_req) begin
        wb   = wb_data_out;
        done = 1'b1;
      end else begin
        stalls++;
      end
    end
    if (!done) to = 1'b1;
  endtask

  // Issue one op (inputs change 1ns after a rising edge), push its expected
  // writeback, wait for completion, pop the expectation, release inputs.
  task automatic run_op(input bit ld, input bit st, input logic [31:0] addr,
                        input logic [31:0] data, input logic [31:0] exp_wb,
                        output int stalls, output logic [31:0] wb,
                        output logic [31:0] exp, output bit to);
    issue(ld, st, addr, data);
    exp_q.push_back(exp_wb);
    wait_ready(stalls, wb, to);
    exp = exp_q.pop_front();
    @(posedge clk);
    #1;
    drive_idle();
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    drive_idle();
    alu_result_in = 32'h1234_5678;
    rd_in         = 5'h13;
    is_write_in   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (stall_req !== 1'b0) begin
      bad++; $display("FAIL reset_stall: got %b want 0", stall_req);
    end
    total++;
    if (wb_data_out !== 32'h1234_5678) begin
      bad++; $display("FAIL reset_wb_pass: got %h want 12345678", wb_data_out);
    end
    total++;
    if (rd_out !== 5'h13 || is_write_out !== 1'b1) begin
      bad++; $display("FAIL reset_fwd: got rd=%h w=%b want rd=13 w=1", rd_out, is_write_out);
    end
    reset = 1'b0;
    rd_in = 5'h07;
    is_write_in = 1'b0;
    #1;
    total++;
    if (rd_out !== 5'h07 || is_write_out !== 1'b0) begin
      bad++; $display("FAIL fwd_change: got rd=%h w=%b want rd=07 w=0", rd_out, is_write_out);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_passthrough();
    int st; logic [31:0] wb, exp; bit to;
    run_op(1'b0, 1'b0, 32'h0000_ABCD, 32'h0, 32'h0000_ABCD, st, wb, exp, to);
    total++;
    if (to || st != 0) begin
      bad++; $display("FAIL pass_stall: got %0d cycles to=%0d want 0", st, to);
    end
    total++;
    if (wb !== exp) begin
      bad++; $display("FAIL pass_wb: got %h want %h", wb, exp);
    end
  endtask

  task automatic test_load_miss();
    int st; logic [31:0] wb, exp; bit to;
    issue(1'b1, 1'b0, 32'h100, 32'h0);
    #1;
    total++;
    if (stall_req !== 1'b1) begin
      bad++; $display("FAIL miss_req_cycle_stall: got %b want 1", stall_req);
    end
    exp_q.push_back(32'hCAFE_BABE);
    wait_ready(st, wb, to);
    exp = exp_q.pop_front();
    @(posedge clk);
    #1;
    drive_idle();
    total++;
    if (to || st != OP_STALLS) begin
      bad++; $display("FAIL miss_stall_len: got %0d cycles to=%0d want %0d", st, to, OP_STALLS);
    end
    total++;
    if (wb !== exp) begin
      bad++; $display("FAIL miss_data: got %h want %h", wb, exp);
    end
  endtask

  task automatic test_load_hit();
    int st; logic [31:0] wb, exp; bit to;
    run_op(1'b1, 1'b0, 32'h100, 32'h0, 32'hCAFE_BABE, st, wb, exp, to);
    total++;
    if (to || st != 0) begin
      bad++; $display("FAIL hit_stall: got %0d cycles to=%0d want 0", st, to);
    end
    total++;
    if (wb !== exp) begin
      bad++; $display("FAIL hit_data: got %h want %h", wb, exp);
    end
    // Same line, next word: hit, initial memory content 0.
    run_op(1'b1, 1'b0, 32'h104, 32'h0, 32'h0, st, wb, exp, to);
    total++;
    if (to || st != 0 || wb !== exp) begin
      bad++; $display("FAIL hit_word1: got %0d cycles data %h want 0 cycles %h", st, wb, exp);
    end
  endtask

  task automatic test_store_hit();
    int st; logic [31:0] wb, exp; bit to;
    run_op(1'b0, 1'b1, 32'h100, 32'h0000_9999, 32'h100, st, wb, exp, to);
    total++;
    if (to || st != OP_STALLS) begin
      bad++; $display("FAIL store_stall_len: got %0d cycles to=%0d want %0d", st, to, OP_STALLS);
    end
    total++;
    if (wb !== exp) begin
      bad++; $display("FAIL store_done_wb: got %h want %h", wb, exp);
    end
    run_op(1'b1, 1'b0, 32'h100, 32'h0, 32'h0000_9999, st, wb, exp, to);
    total++;
    if (to || st != 0 || wb !== exp) begin
      bad++; $display("FAIL store_update: got %0d cycles data %h want 0 cycles %h", st, wb, exp);
    end
  endtask

  task automatic test_store_miss();
    int st; logic [31:0] wb, exp; bit to;
    run_op(1'b0, 1'b1, 32'h200, 32'h0000_0055, 32'h200, st, wb, exp, to);
    total++;
    if (to || st != OP_STALLS) begin
      bad++; $display("FAIL smiss_stall_len: got %0d cycles to=%0d want %0d", st, to, OP_STALLS);
    end
    // No allocation: the load must miss and fetch the written-through value.
    run_op(1'b1, 1'b0, 32'h200, 32'h0, 32'h0000_0055, st, wb, exp, to);
    total++;
    if (to || st != OP_STALLS || wb !== exp) begin
      bad++; $display("FAIL smiss_load: got %0d cycles data %h want %0d cycles %h", st, wb, OP_STALLS, exp);
    end
    // 0x100 was evicted by 0x200 (same index); memory must hold the stored value.
    run_op(1'b1, 1'b0, 32'h100, 32'h0, 32'h0000_9999, st, wb, exp, to);
    total++;
    if (to || st != OP_STALLS || wb !== exp) begin
      bad++; $display("FAIL write_through: got %0d cycles data %h want %0d cycles %h", st, wb, OP_STALLS, exp);
    end
  endtask

  task automatic test_back_to_back();
    int st; logic [31:0] wb, exp; bit to;
    run_op(1'b0, 1'b1, 32'h300, 32'hA5A5_0001, 32'h300, st, wb, exp, to);
    total++;
    if (to || st != OP_STALLS) begin
      bad++; $display("FAIL b2b_store1: got %0d cycles want %0d", st, OP_STALLS);
    end
    run_op(1'b0, 1'b1, 32'h304, 32'hA5A5_0002, 32'h304, st, wb, exp, to);
    total++;
    if (to || st != OP_STALLS) begin
      bad++; $display("FAIL b2b_store2: got %0d cycles want %0d", st, OP_STALLS);
    end
    run_op(1'b1, 1'b0, 32'h304, 32'h0, 32'hA5A5_0002, st, wb, exp, to);
    total++;
    if (to || st != OP_STALLS || wb !== exp) begin
      bad++; $display("FAIL b2b_load2: got %0d cycles data %h want %0d cycles %h", st, wb, OP_STALLS, exp);
    end
    run_op(1'b1, 1'b0, 32'h300, 32'h0, 32'hA5A5_0001, st, wb, exp, to);
    total++;
    if (to || st != 0 || wb !== exp) begin
      bad++; $display("FAIL b2b_load1: got %0d cycles data %h want 0 cycles %h", st, wb, exp);
    end
  endtask

  task automatic test_load_and_store();
    int st; logic [31:0] wb, exp; bit to;
    run_op(1'b1, 1'b1, 32'h400, 32'h0000_0077, 32'h400, st, wb, exp, to);
    total++;
    if (to || st != OP_STALLS || wb !== exp) begin
      bad++; $display("FAIL both_as_store: got %0d cycles data %h want %0d cycles %h", st, wb, OP_STALLS, exp);
    end
    run_op(1'b1, 1'b0, 32'h400, 32'h0, 32'h0000_0077, st, wb, exp, to);
    total++;
    if (to || st != OP_STALLS || wb !== exp) begin
      bad++; $display("FAIL both_readback: got %0d cycles data %h want %0d cycles %h", st, wb, OP_STALLS, exp);
    end
  endtask

  task automatic test_reset_mid_access();
    int st; logic [31:0] wb, exp; bit to;
    // Bring 0x100 into the cache and confirm it hits.
    run_op(1'b1, 1'b0, 32'h100, 32'h0, 32'h0000_9999, st, wb, exp, to);
    run_op(1'b1, 1'b0, 32'h100, 32'h0, 32'h0000_9999, st, wb, exp, to);
    total++;
    if (to || st != 0 || wb !== exp) begin
      bad++; $display("FAIL pre_reset_hit: got %0d cycles data %h want 0 cycles %h", st, wb, exp);
    end
    // Miss to 0x140, then reset in the middle of RD_WAIT.
    issue(1'b1, 1'b0, 32'h140, 32'h0);
    repeat (5) @(negedge clk);
    #2;
    reset = 1'b1;
    drive_idle();
    #1;
    total++;
    if (stall_req !== 1'b0) begin
      bad++; $display("FAIL rd_abort_stall: got %b want 0", stall_req);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    // Valid bits cleared: 0x100 misses again; memory content survives reset.
    run_op(1'b1, 1'b0, 32'h100, 32'h0, 32'h0000_9999, st, wb, exp, to);
    total++;
    if (to || st != OP_STALLS || wb !== exp) begin
      bad++; $display("FAIL post_reset_miss: got %0d cycles data %h want %0d cycles %h", st, wb, OP_STALLS, exp);
    end
    // Reset during WR_WAIT: the store must not reach memory.
    issue(1'b0, 1'b1, 32'h500, 32'hDEAD_BEEF);
    repeat (6) @(negedge clk);
    #2;
    reset = 1'b1;
    drive_idle();
    #1;
    total++;
    if (stall_req !== 1'b0) begin
      bad++; $display("FAIL wr_abort_stall: got %b want 0", stall_req);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    run_op(1'b1, 1'b0, 32'h500, 32'h0, 32'h0, st, wb, exp, to);
    total++;
    if (to || st != OP_STALLS || wb !== exp) begin
      bad++; $display("FAIL aborted_store: got %0d cycles data %h want %0d cycles %h", st, wb, OP_STALLS, exp);
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_load_miss();
    test_load_hit();
    test_store_hit();
    test_store_miss();
    test_back_to_back();
    test_load_and_store();
    test_reset_mid_access();
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL scoreboard_drain: got %0d entries want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
